// File: rtl/dac_spi_pkg.sv
// Shared types and limits for the DAC SPI scanner (FSM states, parameter ranges).
package dac_spi_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_HOLD} dac_state_e;

  localparam int FRAME_W_MIN = 8;
  localparam int FRAME_W_MAX = 32;
  localparam int DIV_MIN     = 1;
  localparam int DIV_MAX     = 255;
  localparam int N_CH_MIN    = 1;
  localparam int N_CH_MAX    = 8;
  localparam int CS_GAP_MIN  = 1;
  localparam int CS_GAP_MAX  = 15;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// Serial engine for one DAC frame: sclk divider, MSB-first din on sclk rise, cs_n framing
// and a done strobe coincident with cs_n rising.
module dac_spi_shifter #(
  parameter int FRAME_W = 16,
  parameter int DIV     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] load_data,
  output logic               cs_n,
  output logic               sclk,
  output logic               din,
  output logic               last,
  output logic               done
);

  // 2*FRAME_W clocked half-periods plus one trailing low half before cs_n rises
  localparam int HALVES = 2*FRAME_W + 1;
  localparam int HW     = $clog2(HALVES + 1);
  localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1;

  logic               active;
  logic [DW-1:0]      div_cnt;
  logic [HW-1:0]      half;
  logic [FRAME_W-1:0] sreg;
  logic               half_end;

  assign half_end = active && (div_cnt == DW'(DIV - 1));
  assign last     = half_end && (half == HW'(HALVES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      div_cnt <= '0;
      half    <= '0;
      sreg    <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      din     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !active) begin
        active  <= 1'b1;
        div_cnt <= '0;
        half    <= '0;
        cs_n    <= 1'b0;
        sclk    <= 1'b1;
        din     <= load_data[FRAME_W-1];
        sreg    <= {load_data[FRAME_W-2:0], 1'b0};
      end else if (active) begin
        if (!half_end) begin
          div_cnt <= div_cnt + 1'b1;
        end else begin
          div_cnt <= '0;
          half    <= half + 1'b1;
          if (last) begin
            active <= 1'b0;
            cs_n   <= 1'b1;
            sclk   <= 1'b0;
            din    <= 1'b0;
            done   <= 1'b1;
          end else if (half[0]) begin
            // odd -> even half is a rising edge, except into the trailing low half
            if (half != HW'(HALVES - 2)) begin
              sclk <= 1'b1;
              din  <= sreg[FRAME_W-1];
              sreg <= {sreg[FRAME_W-2:0], 1'b0};
            end
          end else begin
            sclk <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dac_spi_scan.sv
// Multi-channel DAC SPI scanner: shadow registers, pending bits, round-robin arbiter and FSM.
// Build option: DAC_SPI_OVERWRITE_EN makes wr_ready constant 1 and lets new writes replace queued data.
module dac_spi_scan import dac_spi_pkg::*; #(
  parameter  int FRAME_W = 16,
  parameter  int DIV     = 2,
  parameter  int N_CH    = 2,
  parameter  int CS_GAP  = 2,
  localparam int CH_W    = ch_width(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [FRAME_W-1:0] wr_data,
  output logic               busy,
  output logic               frame_done,
  output logic [CH_W-1:0]    frame_ch,
  output logic               dac_cs_n,
  output logic               dac_din,
  output logic               dac_sclk
);

  // Between back-to-back frames cs_n stays high CS_GAP*DIV cycles, LOAD being the last of them
  localparam int GAP_CYC  = CS_GAP * DIV;
  localparam int HOLD_CYC = (GAP_CYC > 1) ? GAP_CYC - 1 : 1;
  localparam int HC_W     = $clog2(HOLD_CYC + 1);

  dac_state_e                   state_q, state_d;
  logic [N_CH-1:0][FRAME_W-1:0] shadow_q;
  logic [N_CH-1:0]              pending_q;
  logic [CH_W-1:0]              rr_q, sel, cur_ch_q;
  logic [HC_W-1:0]              hold_q;
  logic                         in_range, wr_fire, load, sh_last;

  assign in_range = (int'(wr_ch) < N_CH);
`ifdef DAC_SPI_OVERWRITE_EN
  assign wr_ready = 1'b1;
`else
  assign wr_ready = in_range ? !pending_q[wr_ch] : 1'b1;
`endif
  assign wr_fire = wr_valid && wr_ready && in_range;
  assign load    = (state_q == ST_LOAD);
  assign busy    = (state_q != ST_IDLE);

  // Scan downwards so the pending channel closest after rr_q wins
  always_comb begin
    logic [CH_W-1:0] idx;
    idx = '0;
    sel = rr_q;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr_q) + i) % N_CH);
      if (pending_q[idx]) sel = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|pending_q) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (sh_last) state_d = ST_HOLD;
      ST_HOLD:  if (hold_q == HC_W'(HOLD_CYC - 1)) state_d = (|pending_q) ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_q == ST_HOLD) ? hold_q + 1'b1 : '0;
    end
  end

  // A write landing in the LOAD cycle is applied after the clear, so it wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      pending_q <= '0;
      rr_q      <= '0;
      cur_ch_q  <= '0;
      frame_ch  <= '0;
    end else begin
      if (load) begin
        pending_q[sel] <= 1'b0;
        rr_q           <= (int'(sel) == N_CH - 1) ? '0 : sel + 1'b1;
        cur_ch_q       <= sel;
      end
      if (wr_fire) begin
        shadow_q[wr_ch]  <= wr_data;
        pending_q[wr_ch] <= 1'b1;
      end
      if (sh_last) frame_ch <= cur_ch_q;
    end
  end

  dac_spi_shifter #(.FRAME_W(FRAME_W), .DIV(DIV)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (load),
    .load_data (shadow_q[sel]),
    .cs_n      (dac_cs_n),
    .sclk      (dac_sclk),
    .din       (dac_din),
    .last      (sh_last),
    .done      (frame_done)
  );

endmodule

// File: tb/tb_dac_spi_scan.sv
// Randomized bench for dac_spi_scan against a frame-level reference model decoded from the bus.
module tb_dac_spi_scan;
  localparam int FRAME_W = 16, DIV = 2, N_CH = 2, CS_GAP = 2;
  localparam int LOW_CYC = (2*FRAME_W + 1) * DIV;
  localparam int GAP_CYC = CS_GAP * DIV;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_valid = 1'b0, wr_ready, busy, frame_done, dac_cs_n, dac_din, dac_sclk;
  logic [0:0] wr_ch = '0, frame_ch;
  logic [FRAME_W-1:0] wr_data = '0;
  logic wr_valid3 = 1'b0, wr_ready3, busy3, frame_done3, cs_n3, din3, sclk3;
  logic [1:0] wr_ch3 = '0, frame_ch3;
  logic [FRAME_W-1:0] wr_data3 = '0;

  always #5 clk = ~clk;

  dac_spi_scan #(.FRAME_W(FRAME_W), .DIV(DIV), .N_CH(N_CH), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_data(wr_data), .busy(busy), .frame_done(frame_done), .frame_ch(frame_ch),
    .dac_cs_n(dac_cs_n), .dac_din(dac_din), .dac_sclk(dac_sclk));

  dac_spi_scan #(.FRAME_W(FRAME_W), .DIV(DIV), .N_CH(3), .CS_GAP(CS_GAP)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_ch(wr_ch3),
    .wr_data(wr_data3), .busy(busy3), .frame_done(frame_done3), .frame_ch(frame_ch3),
    .dac_cs_n(cs_n3), .dac_din(din3), .dac_sclk(sclk3));

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: channel shadows, pending set, round-robin start point
  logic [FRAME_W-1:0] m_shadow [N_CH];
  bit                 m_pend   [N_CH];
  int                 m_rr;
  // Bus monitor state
  bit prev_cs = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0, b2b = 1'b0;
  int low_cnt, high_cnt, nbits, exp_ch, frames = 0, last_gap, last_ch;
  logic [FRAME_W-1:0] cap, exp_data, last_data;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin m_shadow[i] = '0; m_pend[i] = 1'b0; end
    m_rr = 0; prev_cs = 1'b1; prev_sclk = 1'b0; in_frame = 1'b0; b2b = 1'b0;
    high_cnt = 0; low_cnt = 0; nbits = 0;
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < N_CH; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready(input int ch);
`ifdef DAC_SPI_OVERWRITE_EN
    return 1'b1;
`else
    return (ch >= N_CH) || !m_pend[ch];
`endif
  endfunction

  task automatic observe();
    bit found, rise;
    if (prev_cs && !dac_cs_n) begin
      found = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        int c = (m_rr + i) % N_CH;
        if (!found && m_pend[c]) begin
          found = 1'b1; exp_ch = c; exp_data = m_shadow[c]; m_pend[c] = 1'b0; m_rr = (c + 1) % N_CH;
        end
      end
      if (!found) chk("spurious_frame", 1, 0);
      if (b2b) chk("cs_gap", high_cnt, GAP_CYC);
      last_gap = high_cnt; in_frame = found; nbits = 0; cap = '0; low_cnt = 0;
    end
    if (!dac_cs_n) begin
      low_cnt++;
      chk("busy_in_frame", busy, 1);
      if (prev_sclk && !dac_sclk) begin cap = {cap[FRAME_W-2:0], dac_din}; nbits++; end
    end else begin
      high_cnt++;
      chk("sclk_idle", dac_sclk, 0);
    end
    rise = !prev_cs && dac_cs_n;
    chk("frame_done", frame_done, rise);
    if (rise && in_frame) begin
      chk("frame_bits", nbits, FRAME_W);
      chk("frame_data", cap, exp_data);
      chk("cs_low_cycles", low_cnt, LOW_CYC);
      chk("frame_ch", frame_ch, exp_ch);
      last_data = cap; last_ch = exp_ch; in_frame = 1'b0; high_cnt = 1; b2b = any_pend(); frames++;
    end
    prev_cs = dac_cs_n; prev_sclk = dac_sclk;
  endtask

  // One clock: drive at posedge+1, check ready at negedge, observe bus at next posedge+1
  task automatic step(input bit v, input int ch, input logic [FRAME_W-1:0] d, output bit acc);
    wr_valid = v; wr_ch = ch[0:0]; wr_data = d;
    @(negedge clk);
    if (v) chk("wr_ready", wr_ready, m_ready(ch));
    acc = v && m_ready(ch);
    @(posedge clk); #1;
    observe();
    if (acc && ch < N_CH) begin m_shadow[ch] = d; m_pend[ch] = 1'b1; end
    wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, 0, '0, a);
  endtask

  task automatic wr(input int ch, input logic [FRAME_W-1:0] d, output int stalls);
    bit acc; int n = 0;
    do begin step(1'b1, ch, d, acc); n++; end while (!acc && n < 400);
    if (!acc) chk("wr_timeout", 0, 1);
    stalls = n - 1;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!in_frame && n < 500) begin idle(1); n++; end
    chk("frame_start_timeout", in_frame, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((in_frame || any_pend() || !dac_cs_n) && n < 3000) begin idle(1); n++; end
    chk("drain_timeout", n < 3000, 1);
    idle(GAP_CYC + 2);
    chk("busy_after_drain", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, f0, n;
    bit seen;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", dac_cs_n, 1); chk("rst_sclk", dac_sclk, 0); chk("rst_din", dac_din, 0);
    chk("rst_frame_done", frame_done, 0); chk("rst_frame_ch", frame_ch, 0);
    chk("rst_busy", busy, 0); chk("rst_wr_ready", wr_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, known pattern
    wr(0, 16'hC5A3, s); drain();
    chk("s31_data", last_data, 16'hC5A3); chk("s31_ch", last_ch, 0);

    // Two channels back to back
    f0 = frames;
    wr(1, 16'h1234, s); wr(0, 16'hABCD, s); drain();
    chk("s32_frames", frames - f0, 2); chk("s32_gap", last_gap, GAP_CYC);
    chk("s32_last_data", last_data, 16'hABCD); chk("s32_last_ch", last_ch, 0);

    // Second write to a queued channel during another channel's frame
    f0 = frames;
    wr(1, 16'h5555, s); wait_frame();
    wr(0, 16'h1111, s); wr(0, 16'h2222, s);
`ifdef DAC_SPI_OVERWRITE_EN
    chk("s33_stall", s, 0);
    drain(); chk("s33_frames", frames - f0, 2);
`else
    chk("s33_stall", s > 0, 1);
    drain(); chk("s33_frames", frames - f0, 3);
`endif
    chk("s33_last_data", last_data, 16'h2222);

    // Rewrite a channel while its own frame is shifting
    f0 = frames;
    wr(0, 16'h0F0F, s); wait_frame(); idle(5); wr(0, 16'hF00F, s); drain();
    chk("s34_frames", frames - f0, 2); chk("s34_last_data", last_data, 16'hF00F);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      bit a;
      step($urandom_range(0, 5) == 0, int'($urandom_range(0, N_CH - 1)), FRAME_W'($urandom), a);
    end
    drain();

    // Asynchronous reset mid-frame
    wr(1, 16'hF0F0, s); wait_frame();
    n = 0;
    while (nbits < 7 && n < 200) begin idle(1); n++; end
    chk("s35_reach_bit7", nbits, 7);
    f0 = frames;
    #2 rst_n = 1'b0;
    #1;
    chk("s35_cs_n", dac_cs_n, 1); chk("s35_sclk", dac_sclk, 0); chk("s35_din", dac_din, 0);
    chk("s35_busy", busy, 0); chk("s35_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    idle(200);
    chk("s35_no_frame", frames - f0, 0); chk("s35_idle_busy", busy, 0);

    // Out-of-range channel on a 3-channel instance
    wr_ch3 = 2'd3; wr_data3 = 16'hBEEF; wr_valid3 = 1'b1;
    @(negedge clk);
    chk("s36_ready", wr_ready3, 1);
    @(posedge clk); #1;
    wr_valid3 = 1'b0; seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (busy3 || !cs_n3 || frame_done3) seen = 1'b1;
    end
    chk("s36_no_activity", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
